// File: rtl/fifo_rd_pkg.sv
// Shared types, defaults and width helpers for the FIFO read-stream engine.
// Optional feature macro used by the top level: FIFO_RD_COUNT_EN (rd_count port).
package fifo_rd_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  typedef logic [CNT_W_DEFAULT-1:0] rd_count_t;

  // Output buffer fill classification
  typedef enum logic [1:0] {
    BufEmpty,
    BufPartial,
    BufFull
  } buf_state_e;

  // Ceiling log2; returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic buf_state_e buf_state(input int unsigned occ, input int unsigned depth);
    if (occ == 0) return BufEmpty;
    if (occ >= depth) return BufFull;
    return BufPartial;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the read engine.
// master: the read engine. slave: the FIFO/consumer environment around it.
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_re;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_re,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_re,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular BUF_DEPTH x DATA_W output buffer. Owns read/write pointers and occupancy.
// Head reads as zero while empty so the stream data is clean when not valid.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned BUF_DEPTH = 3,
  localparam int unsigned OCC_W    = clog2(BUF_DEPTH + 1),
  localparam int unsigned PTR_W    = clog2(BUF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [OCC_W-1:0]  o_occ
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write at the tail
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy update; push and pop in the same cycle cancel in occ
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
    end
  end

  // Head presentation, zeroed when empty
  always_comb begin
    o_head = '0;
    if (r_occ != '0) o_head = r_mem[r_rd_ptr];
    o_occ = r_occ;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine for the 16x8 FIFO: pops words and streams them out on valid/ready.
// The FIFO has one cycle of read latency; reads are only issued when the buffer has a
// slot reserved for every word in flight, so nothing is ever dropped.
// Optional: define FIFO_RD_COUNT_EN to add the o_rd_count accepted-transfer counter.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
`ifdef FIFO_RD_COUNT_EN
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
`endif
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
`ifdef FIFO_RD_COUNT_EN
  output logic [CNT_W-1:0]        o_rd_count,
`endif
  fifo_rd_stream_if.master        io_bus
);

  localparam int unsigned OCC_W = clog2(BUF_DEPTH + 1);

  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W:0]    w_inflight;
  logic [DATA_W-1:0] w_head;
  logic              w_fifo_re;
  logic              w_out_valid;
  logic              w_pop;
  buf_state_e        w_buf_state;
  logic              r_pending;

  // Issue rule and stream handshake; out_ready never reaches fifo_re
  always_comb begin
    w_inflight  = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_pending};
    w_buf_state = buf_state(32'(w_occ), BUF_DEPTH);
    w_fifo_re   = !i_rst && !io_bus.fifo_empty && (w_inflight < (OCC_W + 1)'(BUF_DEPTH));
    w_out_valid = (w_buf_state != BufEmpty);
    w_pop       = w_out_valid && io_bus.out_ready;
  end

  // Pending marks a FIFO read whose data lands on fifo_data this cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pending <= 1'b0;
    else       r_pending <= w_fifo_re;
  end

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_W-1:0] r_rd_count;

  // Accepted-transfer counter, wraps naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_rd_count <= '0;
    else if (w_pop) r_rd_count <= r_rd_count + CNT_W'(1);
  end

  assign o_rd_count = r_rd_count;
`endif

  fifo_rd_skid_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_pending),
    .i_push_data (io_bus.fifo_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  assign io_bus.fifo_re   = w_fifo_re;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_data  = w_head;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, directed scenarios and a random phase.
// Reference: words issued minus words delivered is the buffer commitment; a word
// becomes visible two cycles after its read; outputs follow FIFO write order.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 3;
`ifdef FIFO_RD_COUNT_EN
  localparam int unsigned CW    = 4;
  logic [CW-1:0] rd_count;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_W(DW)) bus ();

  fifo_rd_stream #(
    .DATA_W    (DW),
`ifdef FIFO_RD_COUNT_EN
    .CNT_W     (CW),
`endif
    .BUF_DEPTH (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef FIFO_RD_COUNT_EN
    .o_rd_count (rd_count),
`endif
    .io_bus     (bus)
  );

  // Behavioural FIFO: contents in fmem, registered read data
  logic [7:0] fmem [0:1023];
  int wr_idx = 0;
  int rd_idx;

  assign bus.fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx        <= 0;
      bus.fifo_data <= '0;
    end else if (bus.fifo_re) begin
      bus.fifo_data <= fmem[rd_idx[9:0]];
      rd_idx        <= rd_idx + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int   issued;
  int   delivered;
  int   last_re;
  logic m_exp_re;
  logic m_exp_v;

  always @(negedge clk) begin
    if (rst) begin
      issued    = 0;
      delivered = 0;
      last_re   = 0;
    end else begin
      m_exp_re = (rd_idx != wr_idx) && ((issued - delivered) < int'(DEPTH));
      m_exp_v  = (issued - last_re - delivered) > 0;
      check_eq("fifo_re", 32'(bus.fifo_re), 32'(m_exp_re));
      check_eq("out_valid", 32'(bus.out_valid), 32'(m_exp_v));
      check_eq("out_data", 32'(bus.out_data), m_exp_v ? 32'(fmem[delivered[9:0]]) : 32'd0);
`ifdef FIFO_RD_COUNT_EN
      check_eq("rd_count", 32'(rd_count), 32'(delivered % (1 << CW)));
`endif
      last_re = int'(bus.fifo_re);
      issued  = issued + int'(bus.fifo_re);
      if (bus.out_valid && bus.out_ready) delivered = delivered + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset and empty the FIFO; caller loads and releases
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    wr_idx = 0;
    step(2);
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx[9:0]] = base + 8'(i);
      wr_idx++;
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    step(3);
    rst = 1'b0;

    // Empty FIFO: nothing issued or presented
    step(10);
    check_eq("t1_issued", 32'(issued), 32'd0);
    check_eq("t1_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t1_data", 32'(bus.out_data), 32'd0);

    // 15 words streamed back to back
    do_reset();
    load(15, 8'h11);
    rst = 1'b0;
    step(20);
    check_eq("t2_delivered", 32'(delivered), 32'd15);
    check_eq("t2_valid_end", 32'(bus.out_valid), 32'd0);

    // Stalled consumer: exactly DEPTH reads, head held
    do_reset();
    load(16, 8'h30);
    bus.out_ready = 1'b0;
    rst = 1'b0;
    step(10);
    check_eq("t3_issued", 32'(issued), 32'(DEPTH));
    check_eq("t3_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t3_head", 32'(bus.out_data), 32'h30);
    bus.out_ready = 1'b1;
    step(25);
    check_eq("t3_delivered", 32'(delivered), 32'd16);

    // Single word with toggling ready
    do_reset();
    load(1, 8'hA5);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = ~bus.out_ready;
      step(1);
    end
    check_eq("t4_issued", 32'(issued), 32'd1);
    check_eq("t4_delivered", 32'(delivered), 32'd1);
    check_eq("t4_valid_end", 32'(bus.out_valid), 32'd0);

    // Async reset with occ=2, pending=1
    do_reset();
    load(10, 8'h40);
    bus.out_ready = 1'b0;
    rst = 1'b0;
    step(3);
    check_eq("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t5_pre_re", 32'(bus.fifo_re), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_rst_re", 32'(bus.fifo_re), 32'd0);
    check_eq("t5_rst_data", 32'(bus.out_data), 32'd0);
    wr_idx = 0;
    step(2);
    load(8, 8'h60);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    step(15);
    check_eq("t5_delivered", 32'(delivered), 32'd8);

`ifdef FIFO_RD_COUNT_EN
    // Counter wrap with CW=4
    do_reset();
    load(17, 8'h70);
    rst = 1'b0;
    step(25);
    check_eq("t6_rd_count", 32'(rd_count), 32'd1);
`endif

    // Random traffic and random consumer back-pressure
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && wr_idx < 1000) begin
        fmem[wr_idx[9:0]] = 8'($urandom);
        wr_idx++;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    bus.out_ready = 1'b1;
    step(40);
    check_eq("rand_all_delivered", 32'(delivered), 32'(wr_idx));
    check_eq("rand_valid_end", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
